// File: rtl/keypad_pkg.sv
// Shared types and the physical key map for the 4x4 lock keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;

    localparam logic [3:0] KEY_STAR = 4'hE;
    localparam logic [3:0] KEY_HASH = 4'hF;

    // Indexed {row, col}; entry 0 (row 0, col 0) is the rightmost nibble.
    localparam logic [15:0][3:0] KEYMAP = {
        4'hD, KEY_HASH, 4'h0, KEY_STAR,
        4'hC, 4'h9,     4'h8, 4'h7,
        4'hB, 4'h6,     4'h5, 4'h4,
        4'hA, 4'h3,     4'h2, 4'h1
    };

    // A usable sample has exactly one row pulled low; idle and ghosted samples are rejected.
    function automatic logic row_valid(input logic [3:0] row_n);
        return ($countones(~row_n) == 1);
    endfunction

    function automatic logic [1:0] row_index(input logic [3:0] row_n);
        case (row_n)
            4'b1101: return 2'd1;
            4'b1011: return 2'd2;
            4'b0111: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad matrix and key-event signals between the scanner and its neighbours.
interface keypad_scanner_if;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    modport master (input row_n, output col_n, key_code, key_valid, key_held);
    modport slave  (output row_n, input col_n, key_code, key_valid, key_held);
endinterface

// File: rtl/keypad_scanner_tick_sync.sv
// Brings a slow divider output into the system clock domain as a one-cycle tick on its rising edge.
module tick_sync (
    input  logic Clk_100M,
    input  logic rst,
    input  logic slow_clk,
    output logic tick
);
    logic sync_1;
    logic sync_2;
    logic hist;

    // All flops reset high so a slow_clk already high at reset release does not tick.
    always_ff @(posedge Clk_100M) begin
        if (rst) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
            hist   <= 1'b1;
        end else begin
            sync_1 <= slow_clk;
            sync_2 <= sync_1;
            hist   <= sync_2;
        end
    end

    assign tick = sync_2 & ~hist;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: rotates one low column per tick, debounces row returns, emits one code per press.
//   state    | meaning
//   SCAN     | no key; advance column each tick until exactly one row reads low
//   DEBOUNCE | counting consecutive ticks with the same row low on this column
//   PRESSED  | key accepted and still down
//   RELEASE  | rows idle, counting ticks before declaring the key released
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = 8,
    parameter int RELEASE_TICKS  = 2,
    parameter int CNT_W          = 4
) (
    input  logic             Clk_100M,
    input  logic             rst,
    input  logic             slow_clk,
    keypad_scanner_if.master kp
);
    localparam logic [CNT_W-1:0] DEB_LIM = CNT_W'(DEBOUNCE_TICKS);
    localparam logic [CNT_W-1:0] REL_LIM = CNT_W'(RELEASE_TICKS);

    logic             tick;
    logic [3:0]       row_s1, row_s2;
    state_t           state_q, state_d;
    logic [1:0]       column_q, column_d;
    logic [1:0]       row_q, row_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [3:0]       code_d;
    logic             valid_d;
    logic             sample_ok;
    logic [1:0]       sample_row;

    tick_sync u_tick_sync (
        .Clk_100M (Clk_100M),
        .rst      (rst),
        .slow_clk (slow_clk),
        .tick     (tick)
    );

    assign sample_ok  = row_valid(row_s2);
    assign sample_row = row_index(row_s2);
    assign cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        column_d = column_q;
        row_d    = row_q;
        cnt_d    = cnt_q;
        code_d   = kp.key_code;
        valid_d  = 1'b0;
        if (tick) begin
            unique case (state_q)
                SCAN: begin
                    if (sample_ok) begin
                        row_d   = sample_row;
                        cnt_d   = CNT_W'(1);
                        state_d = DEBOUNCE;
                    end else begin
                        column_d = column_q + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (sample_ok && (sample_row == row_q)) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= DEB_LIM) begin
                            state_d = PRESSED;
                            code_d  = KEYMAP[{row_q, column_q}];
                            valid_d = 1'b1;
                        end
                    end else begin
                        // Stay on this column so the next tick re-qualifies it.
                        state_d = SCAN;
                        cnt_d   = '0;
                    end
                end
                PRESSED: begin
                    if (!sample_ok) begin
                        state_d = RELEASE;
                        cnt_d   = CNT_W'(1);
                    end
                end
                RELEASE: begin
                    if (!sample_ok) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= REL_LIM) begin
                            state_d  = SCAN;
                            cnt_d    = '0;
                            column_d = column_q + 2'd1;
                        end
                    end else begin
                        state_d = PRESSED;
                        cnt_d   = '0;
                    end
                end
                default: state_d = SCAN;
            endcase
        end
    end

    always_ff @(posedge Clk_100M) begin
        if (rst) begin
            row_s1       <= 4'hF;
            row_s2       <= 4'hF;
            state_q      <= SCAN;
            column_q     <= 2'd0;
            row_q        <= 2'd0;
            cnt_q        <= '0;
            kp.key_code  <= 4'h0;
            kp.key_valid <= 1'b0;
            kp.col_n     <= 4'b1110;
        end else begin
            row_s1       <= kp.row_n;
            row_s2       <= row_s1;
            state_q      <= state_d;
            column_q     <= column_d;
            row_q        <= row_d;
            cnt_q        <= cnt_d;
            kp.key_code  <= code_d;
            kp.key_valid <= valid_d;
            kp.col_n     <= ~(4'b0001 << column_d);
        end
    end

    assign kp.key_held = (state_q == PRESSED) || (state_q == RELEASE);

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a switch-matrix model drives rows from col_n; accepted keys are scoreboarded.
module tb_keypad_scanner;
    import keypad_pkg::*;

    logic Clk_100M = 1'b0;
    logic rst      = 1'b1;
    logic slow_clk = 1'b0;

    keypad_scanner_if kp ();

    keypad_scanner #(
        .DEBOUNCE_TICKS (8),
        .RELEASE_TICKS  (2),
        .CNT_W          (4)
    ) dut (
        .Clk_100M (Clk_100M),
        .rst      (rst),
        .slow_clk (slow_clk),
        .kp       (kp)
    );

    always #5 Clk_100M = ~Clk_100M;

    // pressed[r][c] closes the switch between row r and column c.
    logic [3:0] pressed [4];
    logic [3:0] row_drv;

    always_comb begin
        row_drv = 4'hF;
        for (int r = 0; r < 4; r++) row_drv[r] = ~|(pressed[r] & ~kp.col_n);
    end
    assign kp.row_n = row_drv;

    int         n_chk   = 0;
    int         n_pass  = 0;
    int         n_pulse = 0;
    logic [3:0] exp_q [$];
    logic       prev_valid = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic logic [3:0] col_n_of(input int c);
        return ~(4'b0001 << c);
    endfunction

    always @(negedge Clk_100M) begin
        if (prev_valid) chk("valid_width", 32'(kp.key_valid), 0);
        if (kp.key_valid === 1'b1) begin
            n_pulse++;
            if (exp_q.size() == 0) chk("unexpected_pulse", exp_q.size(), 1);
            else chk("key_code", 32'(kp.key_code), 32'(exp_q.pop_front()));
        end
        prev_valid <= (kp.key_valid === 1'b1);
    end

    task automatic tick();
        @(negedge Clk_100M) slow_clk = 1'b1;
        repeat (4) @(negedge Clk_100M);
        slow_clk = 1'b0;
        repeat (4) @(negedge Clk_100M);
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic wait_col(input int c);
        int k;
        k = 0;
        while (kp.col_n !== col_n_of(c) && k < 8) begin
            tick();
            k++;
        end
        chk("wait_col", 32'(kp.col_n), 32'(col_n_of(c)));
    endtask

    task automatic expect_debounce(input logic [3:0] code);
        int p0;
        exp_q.push_back(code);
        p0 = n_pulse;
        ticks(7);
        chk("early_pulse", n_pulse - p0, 0);
        tick();
        chk("pulse_after_8", n_pulse - p0, 1);
        chk("held_on_accept", 32'(kp.key_held), 1);
    endtask

    task automatic release_and_check();
        for (int r = 0; r < 4; r++) pressed[r] = 4'h0;
        tick();
        chk("held_release_1", 32'(kp.key_held), 1);
        tick();
        chk("held_release_2", 32'(kp.key_held), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        for (int r = 0; r < 4; r++) pressed[r] = 4'h0;
        repeat (4) @(negedge Clk_100M);
        chk("rst_col_n", 32'(kp.col_n), 32'h0E);
        chk("rst_key_code", 32'(kp.key_code), 0);
        chk("rst_key_valid", 32'(kp.key_valid), 0);
        chk("rst_key_held", 32'(kp.key_held), 0);
        rst = 1'b0;

        // Idle rotation
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_col", 32'(kp.col_n), 32'(col_n_of((i + 1) % 4)));
        end
        chk("idle_pulses", n_pulse, 0);
        chk("idle_key_code", 32'(kp.key_code), 0);

        // Key 5 (r1,c1); scanner is sitting on column 1
        pressed[1] = 4'b0010;
        expect_debounce(4'h5);
        ticks(4);
        chk("held_5", 32'(kp.key_held), 1);
        release_and_check();
        chk("col_after_5", 32'(kp.col_n), 32'(col_n_of(2)));

        // Bounce on key 3 (r0,c2)
        p0 = n_pulse;
        pressed[0] = 4'b0100;
        ticks(3);
        pressed[0] = 4'b0000;
        tick();
        chk("bounce_col", 32'(kp.col_n), 32'(col_n_of(2)));
        chk("bounce_no_pulse", n_pulse - p0, 0);
        pressed[0] = 4'b0100;
        expect_debounce(4'h3);
        release_and_check();

        // Ghosting: rows 1 and 2 on column 0
        p0 = n_pulse;
        pressed[1] = 4'b0001;
        pressed[2] = 4'b0001;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("multi_col", 32'(kp.col_n), 32'(col_n_of((3 + i + 1) % 4)));
        end
        chk("multi_no_pulse", n_pulse - p0, 0);
        pressed[1] = 4'b0000;
        pressed[2] = 4'b0000;
        pressed[3] = 4'b0100;
        wait_col(2);
        expect_debounce(KEY_HASH);
        release_and_check();

        // Key 8 held 50 ticks with a one-tick glitch
        wait_col(1);
        pressed[2] = 4'b0010;
        expect_debounce(4'h8);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("held_8_a", 32'(kp.key_held), 1);
        end
        pressed[2] = 4'b0000;
        tick();
        chk("held_glitch", 32'(kp.key_held), 1);
        pressed[2] = 4'b0010;
        for (int i = 0; i < 21; i++) begin
            tick();
            chk("held_8_b", 32'(kp.key_held), 1);
        end
        release_and_check();

        // Reset mid-debounce on key 9 (r2,c2)
        wait_col(2);
        pressed[2] = 4'b0100;
        ticks(5);
        @(negedge Clk_100M) rst = 1'b1;
        @(negedge Clk_100M);
        chk("midrst_col_n", 32'(kp.col_n), 32'h0E);
        chk("midrst_key_code", 32'(kp.key_code), 0);
        chk("midrst_key_valid", 32'(kp.key_valid), 0);
        chk("midrst_key_held", 32'(kp.key_held), 0);
        repeat (3) @(negedge Clk_100M);
        rst = 1'b0;
        wait_col(2);
        expect_debounce(4'h9);
        release_and_check();

        // slow_clk already high at reset release
        p0 = n_pulse;
        @(negedge Clk_100M);
        rst      = 1'b1;
        slow_clk = 1'b1;
        repeat (4) @(negedge Clk_100M);
        rst = 1'b0;
        repeat (10) @(negedge Clk_100M);
        chk("no_tick_after_rst", 32'(kp.col_n), 32'h0E);
        slow_clk = 1'b0;
        repeat (4) @(negedge Clk_100M);
        slow_clk = 1'b1;
        repeat (4) @(negedge Clk_100M);
        chk("first_real_tick", 32'(kp.col_n), 32'h0D);
        slow_clk = 1'b0;
        repeat (4) @(negedge Clk_100M);
        chk("final_no_pulse", n_pulse - p0, 0);

        chk("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
